// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported backing memory between the instruction-fetch port
// (I) and the data-memory port (D). Only one transaction is in flight at a
// time: it is granted in IDLE, presented downstream in ISSUE, and its response
// is collected in WAIT and returned to the owner as a one-cycle pulse.
// D wins ties; an optional starvation guard lets I through after STARVE_LIMIT
// consecutive D wins taken while I was waiting.
//
// Optional feature macro: MEM_PORT_ARB_STARVE_EN
//   defined   -> starvation counter and STARVE_LIMIT override are built
//   undefined -> pure fixed priority, D always wins ties
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   i_req_valid/ready/addr       fetch request handshake and address
//   i_kill                       discard the outstanding fetch response
//   i_resp_valid/data            one-cycle fetch response pulse and data
//   d_req_valid/ready/addr       data request handshake and address
//   d_req_wdata/fcn/typ          store data, 0=read 1=write, mask type
//   d_resp_valid/data            one-cycle data response (also write ack)
//   mem_req_valid/ready          downstream request handshake
//   mem_req_addr/wdata/fcn/typ   downstream request fields (held in ISSUE)
//   mem_resp_valid/data          downstream response / write ack
//   busy                         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_kill,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic              d_req_fcn,
    input  logic [2:0]        d_req_typ,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic              mem_req_fcn,
    output logic [2:0]        mem_req_typ,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic              busy
);

    // Word mask type used for every instruction fetch.
    localparam logic [2:0] MT_W = 3'd3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_i_q, owner_i_d;   // 1 = fetch owns the transaction
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                fcn_q, fcn_d;
    logic [2:0]          typ_q, typ_d;
    logic                kill_q, kill_d;
    logic                i_resp_valid_q, i_resp_valid_d;
    logic                d_resp_valid_q, d_resp_valid_d;
    logic [DATA_W-1:0]   i_resp_data_q, i_resp_data_d;
    logic [DATA_W-1:0]   d_resp_data_q, d_resp_data_d;

    logic                grant_i;
    logic                grant_d;
    logic                starved;

`ifdef MEM_PORT_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starved = (starve_cnt_q == LIMIT);

    // Counts D wins taken while I was also waiting; any I grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_IDLE) begin
            if (grant_i) begin
                starve_cnt_d = 4'd0;
            end else if (grant_d && i_req_valid && !starved) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Grant is purely combinational from the valids; it only takes effect in
    // IDLE, which is where the ready outputs are allowed to rise.
    always_comb begin
        grant_d = d_req_valid && !(i_req_valid && starved);
        grant_i = i_req_valid && !grant_d;
    end

    assign i_req_ready   = (state_q == ST_IDLE) && grant_i;
    assign d_req_ready   = (state_q == ST_IDLE) && grant_d;
    assign busy          = (state_q != ST_IDLE);

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_fcn   = fcn_q;
    assign mem_req_typ   = typ_q;

    assign i_resp_valid  = i_resp_valid_q;
    assign i_resp_data   = i_resp_data_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_data   = d_resp_data_q;

    always_comb begin
        state_d        = state_q;
        owner_i_d      = owner_i_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        fcn_d          = fcn_q;
        typ_d          = typ_q;
        kill_d         = kill_q;
        i_resp_valid_d = 1'b0;
        d_resp_valid_d = 1'b0;
        i_resp_data_d  = i_resp_data_q;
        d_resp_data_d  = d_resp_data_q;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    owner_i_d = 1'b0;
                    addr_d    = d_req_addr;
                    wdata_d   = d_req_wdata;
                    fcn_d     = d_req_fcn;
                    typ_d     = d_req_typ;
                    state_d   = ST_ISSUE;
                end else if (grant_i) begin
                    owner_i_d = 1'b1;
                    addr_d    = i_req_addr;
                    wdata_d   = '0;
                    fcn_d     = 1'b0;
                    typ_d     = MT_W;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (owner_i_q && i_kill) begin
                    kill_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (owner_i_q && i_kill) begin
                    kill_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                    if (owner_i_q) begin
                        // A kill seen earlier or in this very cycle drops the
                        // fetch response; the held data is left untouched.
                        if (!(kill_q || i_kill)) begin
                            i_resp_valid_d = 1'b1;
                            i_resp_data_d  = mem_resp_data;
                        end
                    end else begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = fcn_q ? '0 : mem_resp_data;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_i_q      <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            fcn_q          <= 1'b0;
            typ_q          <= 3'd0;
            kill_q         <= 1'b0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            i_resp_data_q  <= '0;
            d_resp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            owner_i_q      <= owner_i_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            fcn_q          <= fcn_d;
            typ_q          <= typ_d;
            kill_q         <= kill_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
            i_resp_data_q  <= i_resp_data_d;
            d_resp_data_q  <= d_resp_data_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported backing memory between the core's instruction-fetch port and data-memory port. Accepts at most one transaction at a time, issues it downstream, and routes the response back to the owning requester. Gives data accesses priority, with a starvation guard for fetch. Sits between the five-stage datapath's imem/dmem request bundles and the unified memory model.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, read/write data width
- STARVE_LIMIT, 4, consecutive dmem wins tolerated while fetch waits; range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  ADDR_W  fetch address
- i_kill  in  1  pipeline kill; discards an outstanding fetch response
- i_resp_valid  out  1  one-cycle fetch response pulse
- i_resp_data  out  DATA_W  fetch data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_fcn  in  1  0 = read, 1 = write
- d_req_typ  in  3  memory mask type, forwarded unchanged
- d_resp_valid  out  1  one-cycle data response pulse; also asserted for write acks
- d_resp_data  out  DATA_W  load data; 0 for write acks
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_req_addr  out  ADDR_W  downstream address
- mem_req_wdata  out  DATA_W  downstream store data
- mem_req_fcn  out  1  downstream function; 0 for fetches
- mem_req_typ  out  3  downstream mask type; word type for fetches
- mem_resp_valid  in  1  downstream response or write ack
- mem_resp_data  in  DATA_W  downstream read data
- busy  out  1  high when state is not IDLE; feeds the cache-miss stall

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: grant is combinational from the valid inputs. Exactly one of i_req_ready or d_req_ready is high, and only for a valid requester. On grant, capture addr, wdata, fcn, typ, and owner (I or D) into registers, then go to ISSUE.
- Grant rule: if only one requester is valid, grant it. If both are valid, grant D. The exception is starve_cnt == STARVE_LIMIT, which grants I.
- ISSUE: mem_req_valid = 1 with the registered fields held stable. On mem_req_ready, go to WAIT.
- WAIT: mem_req_valid = 0. On mem_resp_valid, register the data and owner, raise the owner's resp_valid for exactly the next cycle, and return to IDLE.
- Back-to-back: in the cycle resp_valid pulses, the FSM is already in IDLE and may grant a new request.
- starve_cnt: increments (saturating at STARVE_LIMIT) on a D grant while i_req_valid = 1. It clears on any I grant.
- i_kill: when owner = I and i_kill is high in ISSUE or WAIT, set a kill flag. The transaction still completes downstream, but i_resp_valid is suppressed. The flag clears on return to IDLE. i_kill in IDLE has no effect. i_kill never affects D transactions.
- i_kill in the same cycle as mem_resp_valid: the response is dropped.
- Unselected resp_data outputs hold their last value.

## Timing
- Reset values (asynchronous, on rst_n low): state = IDLE; starve_cnt = 0; kill flag = 0; every output = 0 except the ready outputs, which follow the IDLE grant rule combinationally.
- Minimum latency, grant to response pulse, with mem_req_ready = 1 and a 1-cycle memory: grant at cycle 0, mem_req_valid at cycle 1, mem_resp_valid at cycle 2, resp_valid at cycle 3.
- Reset mid-transaction: the transaction is abandoned and no response is produced. The downstream memory shares rst_n.
- A mem_resp_valid arriving outside WAIT is ignored.
- Requesters must hold valid and payload stable until ready.

## Configuration
- MEM_PORT_ARB_STARVE_EN, defined: starve_cnt and the STARVE_LIMIT override are implemented as described.
- MEM_PORT_ARB_STARVE_EN, undefined: pure fixed priority. D always wins ties, starve_cnt is not built, and STARVE_LIMIT is ignored.

## Test plan
- Single fetch: i_req_valid with addr 0x100, memory returns 0xDEADBEEF after 1 cycle -> i_resp_valid pulses for one cycle with 0xDEADBEEF at grant+3; busy high for cycles 1–2.
- Tie: both valid at the same time, D is a write of 0x55 to 0x200 -> D granted first with mem_req_fcn = 1, d_resp_valid with data 0, then I granted in the same cycle d_resp_valid pulses.
- Starvation, macro defined, STARVE_LIMIT = 4: both held valid continuously -> grant order D, D, D, D, I, D…. Macro undefined -> only D is granted while d_req_valid stays high.
- Kill: fetch outstanding in WAIT, i_kill pulsed before mem_resp_valid -> no i_resp_valid; next request is granted normally. Repeat with i_kill coincident with mem_resp_valid -> response dropped.
- Backpressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid and all fields stay stable, and no ready output rises.
- Reset while in WAIT, then release -> state IDLE, all outputs 0, no response pulse; a later request completes normally.
